// File: rtl/vvp_seq.sv
// vvp_seq: bit-plane sequencer for a bit-serial vector-vector product unit.
// Walks every (weight plane, data plane) pair of a job and issues each one to
// the plane memories and the vvp. Each vvp result comes back LAT cycles after
// its issue. The sequencer shifts that result by the plane weight, applies the
// sign of the two's-complement MSB planes, and accumulates it exactly.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a job; start_ready=1
//   ISSUE  | one plane pair issued per cycle, wbit outer / dbit inner
//   DRAIN  | all pairs issued; waiting for the last LAT results to land
//   DONE   | result held on res_data/res_valid until res_ready
module vvp_seq #(
   parameter int N    = 64,
   parameter int LAT  = 0,
   parameter int PMAX = 8,
   parameter int A    = $clog2(N),
   parameter int ACCW = A + 2 + 2*PMAX + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [3:0]               cfg_wprec,
   input  logic [3:0]               cfg_dprec,
   input  logic                     cfg_wsigned,
   input  logic                     cfg_dsigned,
   input  logic [1:0]               cfg_mode,
   output logic                     issue,
   output logic [$clog2(PMAX)-1:0]  wbit_idx,
   output logic [$clog2(PMAX)-1:0]  dbit_idx,
   output logic [1:0]               vvp_mode,
   input  logic signed [A+1:0]      vvp_s,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic signed [ACCW-1:0]   res_data,
   output logic                     busy
);

   localparam int         IW       = $clog2(PMAX);
   localparam int         SHW      = $clog2(2*PMAX);
   localparam logic [3:0] PMAX_P   = 4'(PMAX);
   localparam logic [3:0] DRAIN_LD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   start_hs;
   logic                   last_issue;
   logic                   w_last, d_last;

   logic [3:0]             wp_q, dp_q;
   logic [3:0]             wp_cl, dp_cl;
   logic                   wsigned_q, dsigned_q;
   logic [1:0]             mode_q;
   logic [IW-1:0]          wbit_q, dbit_q;
   logic [3:0]             drain_q;

   logic [SHW-1:0]         cur_shift;
   logic                   cur_neg;
   logic                   al_vld;
   logic [SHW-1:0]         al_shift;
   logic                   al_neg;

   logic signed [ACCW-1:0] vvp_ext;
   logic signed [ACCW-1:0] acc_term;
   logic signed [ACCW-1:0] acc_q;

   assign w_last     = (4'(wbit_q) == (wp_q - 4'd1));
   assign d_last     = (4'(dbit_q) == (dp_q - 4'd1));
   assign last_issue = w_last && d_last;

   // Clamp requested plane counts into 1..PMAX; a zero request means one plane.
   always_comb begin
      wp_cl = cfg_wprec;
      dp_cl = cfg_dprec;
      if (cfg_wprec == 4'd0) begin
         wp_cl = 4'd1;
      end else if (cfg_wprec > PMAX_P) begin
         wp_cl = PMAX_P;
      end
      if (cfg_dprec == 4'd0) begin
         dp_cl = 4'd1;
      end else if (cfg_dprec > PMAX_P) begin
         dp_cl = PMAX_P;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control outputs.
   always_comb begin
      state_d     = state_q;
      start_hs    = 1'b0;
      start_ready = 1'b0;
      issue       = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               start_hs = 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue = 1'b1;
            if (last_issue) begin
               state_d = (LAT > 0) ? S_DRAIN : S_DONE;
            end
         end
         S_DRAIN: begin
            if (drain_q == 4'd0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Job configuration latch and plane index walk (wbit outer, dbit inner).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q      <= 4'd1;
         dp_q      <= 4'd1;
         wsigned_q <= 1'b0;
         dsigned_q <= 1'b0;
         mode_q    <= 2'd0;
         wbit_q    <= '0;
         dbit_q    <= '0;
      end else if (start_hs) begin
         wp_q      <= wp_cl;
         dp_q      <= dp_cl;
         wsigned_q <= cfg_wsigned;
         dsigned_q <= cfg_dsigned;
         mode_q    <= cfg_mode;
         wbit_q    <= '0;
         dbit_q    <= '0;
      end else if (issue) begin
         if (d_last) begin
            dbit_q <= '0;
            wbit_q <= w_last ? '0 : wbit_q + 1'b1;
         end else begin
            dbit_q <= dbit_q + 1'b1;
         end
      end
   end

   // Drain timer: counts down the LAT cycles after the last issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_q <= 4'd0;
      end else if (issue && last_issue) begin
         drain_q <= DRAIN_LD;
      end else if ((state_q == S_DRAIN) && (drain_q != 4'd0)) begin
         drain_q <= drain_q - 4'd1;
      end
   end

   assign wbit_idx = issue ? wbit_q : '0;
   assign dbit_idx = issue ? dbit_q : '0;
   assign vvp_mode = mode_q;

   // Tag of the pair being issued: plane weight and sign of the partial product.
   assign cur_shift = SHW'(wbit_q) + SHW'(dbit_q);
   assign cur_neg   = (wsigned_q && w_last) ^ (dsigned_q && d_last);

   generate
      if (LAT == 0) begin : g_tag_comb
         assign al_vld   = issue;
         assign al_shift = cur_shift;
         assign al_neg   = cur_neg;
      end else begin : g_tag_pipe
         logic           tag_vld_q [LAT];
         logic [SHW-1:0] tag_sh_q  [LAT];
         logic           tag_neg_q [LAT];

         // Tag delay line matching the vvp latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LAT; i++) begin
                  tag_vld_q[i] <= 1'b0;
                  tag_sh_q[i]  <= '0;
                  tag_neg_q[i] <= 1'b0;
               end
            end else begin
               tag_vld_q[0] <= issue;
               tag_sh_q[0]  <= cur_shift;
               tag_neg_q[0] <= cur_neg;
               for (int i = 1; i < LAT; i++) begin
                  tag_vld_q[i] <= tag_vld_q[i-1];
                  tag_sh_q[i]  <= tag_sh_q[i-1];
                  tag_neg_q[i] <= tag_neg_q[i-1];
               end
            end
         end

         assign al_vld   = tag_vld_q[LAT-1];
         assign al_shift = tag_sh_q[LAT-1];
         assign al_neg   = tag_neg_q[LAT-1];
      end
   endgenerate

   // Sign-extend before negating so the most negative vvp_s negates exactly.
   assign vvp_ext  = {{(ACCW-A-2){vvp_s[A+1]}}, vvp_s};
   assign acc_term = (al_neg ? -vvp_ext : vvp_ext) <<< al_shift;

   // Accumulator: cleared on job start, adds only on cycles with an aligned tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (start_hs) begin
         acc_q <= '0;
      end else if (al_vld) begin
         acc_q <= acc_q + acc_term;
      end
   end

   assign res_data = acc_q;

endmodule

// File: tb/tb_vvp_seq.sv
// Directed bench for vvp_seq with LAT=2, N=64. A small vvp stand-in returns
// tbl[wbit][dbit] LAT cycles after each issue and a junk value otherwise.
module tb_vvp_seq;

   localparam int N    = 64;
   localparam int LAT  = 2;
   localparam int PMAX = 8;
   localparam int A    = $clog2(N);
   localparam int ACCW = A + 2 + 2*PMAX + 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start_valid;
   logic                   start_ready;
   logic [3:0]             cfg_wprec, cfg_dprec;
   logic                   cfg_wsigned, cfg_dsigned;
   logic [1:0]             cfg_mode;
   logic                   issue;
   logic [2:0]             wbit_idx, dbit_idx;
   logic [1:0]             vvp_mode;
   logic signed [A+1:0]    vvp_s;
   logic                   res_valid;
   logic                   res_ready;
   logic signed [ACCW-1:0] res_data;
   logic                   busy;

   int n_total = 0;
   int n_bad   = 0;
   int idx_err = 0;
   int base    = 0;
   int tbl [8][8];
   int order_q [$];

   logic       pv [0:LAT] = '{default: 1'b0};
   logic [2:0] pw [0:LAT] = '{default: 3'd0};
   logic [2:0] pd [0:LAT] = '{default: 3'd0};

   vvp_seq #(.N(N), .LAT(LAT), .PMAX(PMAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .cfg_wprec   (cfg_wprec),
      .cfg_dprec   (cfg_dprec),
      .cfg_wsigned (cfg_wsigned),
      .cfg_dsigned (cfg_dsigned),
      .cfg_mode    (cfg_mode),
      .issue       (issue),
      .wbit_idx    (wbit_idx),
      .dbit_idx    (dbit_idx),
      .vvp_mode    (vvp_mode),
      .vvp_s       (vvp_s),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // vvp stand-in: logs issues and replies LAT cycles later, junk when idle.
   always @(negedge clk) begin
      for (int i = LAT; i > 0; i--) begin
         pv[i] = pv[i-1];
         pw[i] = pw[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = issue && !rst;
      pw[0] = wbit_idx;
      pd[0] = dbit_idx;
      if (!rst && issue) order_q.push_back(int'(wbit_idx) * 8 + int'(dbit_idx));
      if (!issue && (wbit_idx != 3'd0 || dbit_idx != 3'd0)) idx_err++;
      vvp_s = pv[LAT] ? 8'(tbl[pw[LAT]][pd[LAT]]) : 8'sd77;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int v);
      for (int w = 0; w < 8; w++)
         for (int d = 0; d < 8; d++)
            tbl[w][d] = v;
   endtask

   task automatic do_start(input int wp, input int dp, input logic ws,
                           input logic ds, input logic [1:0] md);
      cfg_wprec   = 4'(wp);
      cfg_dprec   = 4'(dp);
      cfg_wsigned = ws;
      cfg_dsigned = ds;
      cfg_mode    = md;
      start_valid = 1'b1;
      chk("start_ready", longint'(start_ready), 1);
      base = order_q.size();
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   // Cycle numbering: the handshake cycle is cycle 0.
   task automatic wait_res(input string tag, input int exp_cyc, input int exp_n,
                           input longint exp_res);
      int cyc;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!res_valid && cyc < 300);
      chk({tag, "_cycle"}, longint'(cyc + 1), longint'(exp_cyc));
      chk({tag, "_issues"}, longint'(order_q.size() - base), longint'(exp_n));
      chk({tag, "_res"}, longint'(res_data), exp_res);
   endtask

   task automatic accept();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("accept_idle", longint'(start_ready), 1);
   endtask

   initial begin
      int exp_ord [4];
      rst         = 1'b1;
      start_valid = 1'b0;
      res_ready   = 1'b0;
      cfg_wprec   = 4'd0;
      cfg_dprec   = 4'd0;
      cfg_wsigned = 1'b0;
      cfg_dsigned = 1'b0;
      cfg_mode    = 2'd0;
      fill(0);
      #12;
      chk("rst_start_ready", longint'(start_ready), 1);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_res_valid", longint'(res_valid), 0);
      chk("rst_issue", longint'(issue), 0);
      chk("rst_vvp_mode", longint'(vvp_mode), 0);
      chk("rst_res_data", longint'(res_data), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // 1x1 unsigned
      fill(5);
      do_start(1, 1, 1'b0, 1'b0, 2'd1);
      wait_res("t1", 4, 1, 5);
      chk("t1_mode", longint'(vvp_mode), 1);
      chk("t1_busy", longint'(busy), 1);
      accept();

      // 2x2 unsigned, issue order
      fill(1);
      do_start(2, 2, 1'b0, 1'b0, 2'd0);
      wait_res("t2", 7, 4, 9);
      exp_ord = '{0, 1, 8, 9};
      for (int k = 0; k < 4; k++)
         if (base + k < order_q.size())
            chk("t2_order", longint'(order_q[base+k]), longint'(exp_ord[k]));
      accept();

      // 2x2 both signed: +1 -2 -2 +4
      do_start(2, 2, 1'b1, 1'b1, 2'd0);
      wait_res("t3", 7, 4, 1);
      accept();

      // 8x8 unsigned, 64 * 255 * 255
      fill(64);
      do_start(8, 8, 1'b0, 1'b0, 2'd0);
      wait_res("t4", 67, 64, 4161600);
      accept();

      // clamping: wprec 0 -> 1, dprec 15 -> 8
      do_start(0, 15, 1'b0, 1'b0, 2'd0);
      wait_res("t5", 11, 8, 16320);
      if (order_q.size() > 0)
         chk("t5_last_pair", longint'(order_q[order_q.size()-1]), 7);
      accept();

      // 2x3, weight signed, distinct per-plane values: 19 - 6 = 13
      tbl[0][0] = 3;  tbl[0][1] = -2; tbl[0][2] = 5;
      tbl[1][0] = 7;  tbl[1][1] = -4; tbl[1][2] = 1;
      do_start(2, 3, 1'b1, 1'b0, 2'd2);
      wait_res("t6", 9, 6, 13);
      chk("t6_mode", longint'(vvp_mode), 2);
      accept();

      // most negative vvp_s negated
      fill(-128);
      do_start(1, 1, 1'b1, 1'b0, 2'd0);
      wait_res("t7", 4, 1, 128);
      accept();

      // 8x8 both signed: -128 * (-1) * (-1)
      do_start(8, 8, 1'b1, 1'b1, 2'd0);
      wait_res("t8", 67, 64, -128);
      accept();

      // 8x8 unsigned at most negative input: -128 * 65025
      do_start(8, 8, 1'b0, 1'b0, 2'd0);
      wait_res("t9", 67, 64, -8323200);
      accept();

      // result held with res_ready low; start_valid ignored
      fill(1);
      do_start(2, 2, 1'b0, 1'b0, 2'd0);
      wait_res("t10", 7, 4, 9);
      cfg_wprec   = 4'd1;
      cfg_dprec   = 4'd1;
      start_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("t10_hold_valid", longint'(res_valid), 1);
         chk("t10_hold_data", longint'(res_data), 9);
         chk("t10_hold_sready", longint'(start_ready), 0);
      end
      start_valid = 1'b0;
      chk("t10_no_new_issue", longint'(order_q.size() - base), 4);
      accept();
      tbl[0][0] = 10; tbl[0][1] = 3;
      do_start(1, 2, 1'b0, 1'b0, 2'd0);
      wait_res("t10b", 5, 2, 16);
      accept();

      // reset mid-ISSUE
      fill(1);
      do_start(8, 8, 1'b0, 1'b0, 2'd3);
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("t11_mid_issue", longint'(issue), 1);
      rst = 1'b1;
      #1;
      chk("t11_rst_issue", longint'(issue), 0);
      chk("t11_rst_busy", longint'(busy), 0);
      chk("t11_rst_sready", longint'(start_ready), 1);
      chk("t11_rst_rvalid", longint'(res_valid), 0);
      chk("t11_rst_wbit", longint'(wbit_idx), 0);
      chk("t11_rst_dbit", longint'(dbit_idx), 0);
      chk("t11_rst_mode", longint'(vvp_mode), 0);
      chk("t11_rst_data", longint'(res_data), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t11_no_result", longint'(res_valid), 0);
      fill(-3);
      do_start(1, 1, 1'b0, 1'b0, 2'd0);
      wait_res("t11b", 4, 1, -3);
      accept();

      chk("idx_idle_zero", longint'(idx_err), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/vvp_seq.md
VVP_SEQ -- requirements
Module: vvp_seq

Interface
REQ-001 Parameter N, default 64: vvp vector width; A = $clog2(N).
REQ-002 Parameter LAT, default 0, legal 0..8: vvp pipeline latency in cycles, from plane issue to valid vvp_s.
REQ-003 Parameter PMAX, default 8: maximum bit-plane precision per operand.
REQ-004 Parameter ACCW, default A+2+2*PMAX+1: accumulator and result width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 start_valid / start_ready  in / out  1 / 1  job request handshake.
REQ-008 cfg_wprec, cfg_dprec  in  4 each  weight and data plane counts; sampled on start handshake.
REQ-009 cfg_wsigned, cfg_dsigned  in  1 each  MSB plane of that operand is negative-weighted.
REQ-010 cfg_mode  in  2  vvp mode for the job.
REQ-011 issue  out  1  plane pair (wbit_idx, dbit_idx) presented to plane memories and vvp this cycle.
REQ-012 wbit_idx, dbit_idx  out  3 each  current weight / data plane index.
REQ-013 vvp_mode  out  2  latched cfg_mode, driven to vvp mode port.
REQ-014 vvp_s  in  signed A+2  vvp dot-product result.
REQ-015 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-016 res_data  out  signed ACCW  accumulated dot product.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE; start_ready SHALL be 1 only in IDLE.
REQ-019 IDLE->ISSUE on start handshake: latch configuration; Wp = clamp(cfg_wprec, 1, PMAX) and Dp = clamp(cfg_dprec, 1, PMAX) (0 -> 1; >PMAX -> PMAX); clear accumulator; P = Wp*Dp.
REQ-020 In ISSUE, issue=1 for exactly P consecutive cycles, starting the cycle after the handshake edge.
REQ-021 Issue order SHALL be wbit outer, dbit inner: (0,0),(0,1)..(0,Dp-1),(1,0)..(Wp-1,Dp-1); indices SHALL be 0 when issue=0.
REQ-022 After the last issue: ISSUE->DRAIN if LAT>0; otherwise ISSUE->DONE.
REQ-023 Each issue SHALL carry a tag {shift = wbit+dbit, neg} through an LAT-deep shift register; the tag emerges aligned with the vvp_s of that issue.
REQ-024 neg = (wsigned AND wbit==Wp-1) XOR (dsigned AND dbit==Dp-1).
REQ-025 On each aligned cycle, acc += (neg ? -vvp_s : vvp_s) sign-extended to ACCW, shifted left by shift.
REQ-026 DRAIN->DONE once the last tag has been accumulated; res_valid SHALL first be 1 exactly P+LAT+1 cycles after the start handshake edge.
REQ-027 In DONE, res_valid=1 and res_data=acc, both stable until res_ready=1; DONE->IDLE on the res handshake.
REQ-028 vvp_s SHALL be ignored on cycles with no aligned tag; start_valid SHALL be ignored when not IDLE.
REQ-029 Accumulation SHALL be exact, with no overflow, for all legal configurations.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE; acc, tags, indices, issue, res_valid, busy and vvp_mode = 0; start_ready=1.
REQ-031 Reset in any state SHALL abandon the job with no result; the next job after release SHALL be correct.

Verification (bench LAT=2, N=64)
REQ-032 1x1 unsigned, vvp_s=5 -> res_data=5, res_valid at cycle 4 after the handshake.
REQ-033 2x2 unsigned, vvp_s=1 every plane -> issue order (0,0),(0,1),(1,0),(1,1); res_data=9 at cycle 7.
REQ-034 2x2 both signed, vvp_s=1 -> +1-2-2+4 = 1.
REQ-035 8x8 unsigned, vvp_s=64 -> res_data=4161600; cfg_wprec=0, cfg_dprec=15 -> 8 issues (1x8).
REQ-036 res_ready held low 5 cycles -> res_data stable, start_ready=0, start_valid ignored; accept then immediate new job -> correct.
REQ-037 rst pulsed mid-ISSUE -> all outputs at reset values immediately; following 1x1 job, vvp_s=-3 -> res_data=-3.
